// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle arithmetic/logic ops plus shifts, rotates and
// population count processed STEP bit positions per cycle.
module iter_alu #(
    parameter int WIDTH = 64,
    parameter int STEP  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Flush,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Op,
    input  logic             W64,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Busy
);
    localparam int LW = $clog2(WIDTH);
    localparam int CW = LW + 1;
    localparam int MW = $clog2(STEP) + 1;
    localparam int unsigned STEP_U = STEP;
    localparam int unsigned NW = (32 / STEP > 0) ? 32 / STEP : 1;

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    state_t           state, state_nx;
    logic [3:0]       op_q;
    logic             w_q;
    logic [WIDTH-1:0] acc_q, acc_nx, acc_init;
    logic [LW-1:0]    rem_q, rem_nx, amt_in;
    logic [CW-1:0]    cnt_q, pop_q, pop_nx, last_cnt;
    logic [WIDTH-1:0] result_q, alu_res, iter_res;
    logic [WIDTH-1:0] a_x, b_x;
    logic [2*WIDTH-1:0] dbl;
    logic [63:0]      dbl32;
    logic [MW-1:0]    move;
    logic             w_in, iter_in, accept, last;

    function automatic logic [WIDTH-1:0] fin(input logic w, input logic [WIDTH-1:0] x);
        return w ? WIDTH'($signed(x[31:0])) : x;
    endfunction

    function automatic logic [CW-1:0] pop_step(input logic [WIDTH-1:0] v);
        logic [CW-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < STEP_U; i++) s += CW'(v[i]);
        return s;
    endfunction

    assign accept  = InValid & InReady;
    assign w_in    = (WIDTH == 64) & W64;
    assign iter_in = Op inside {4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1101};
    assign amt_in  = B[LW-1:0] & (w_in ? LW'(31) : '1);

    // W-type ops see sign-extended 32-bit operands; finalising the low word
    // afterwards yields the 32-bit result, and unsigned order is preserved.
    always_comb begin
        a_x = fin(w_in, A);
        b_x = fin(w_in, B);
        case (Op)
            4'b0000: alu_res = a_x + b_x;
            4'b0001: alu_res = a_x + ~b_x + WIDTH'(1);
            4'b0010: alu_res = WIDTH'($signed(a_x) < $signed(b_x));
            4'b0011: alu_res = WIDTH'(a_x < b_x);
            4'b0100: alu_res = a_x ^ b_x;
            4'b0110: alu_res = a_x | b_x;
            4'b0111: alu_res = a_x & b_x;
            default: alu_res = '0;
        endcase
        alu_res  = fin(w_in, alu_res);
        acc_init = (Op == 4'b1010) ? a_x : (w_in ? WIDTH'(A[31:0]) : A);
    end

    always_comb begin
        move     = (32'(rem_q) > STEP_U) ? MW'(STEP_U) : MW'(rem_q);
        rem_nx   = rem_q - LW'(move);
        pop_nx   = pop_q;
        dbl      = '0;
        dbl32    = '0;
        last_cnt = w_q ? CW'(NW - 1) : CW'(WIDTH / STEP - 1);
        case (op_q)
            4'b1000: acc_nx = acc_q << move;
            4'b1001: acc_nx = acc_q >> move;
            4'b1010: acc_nx = $signed(acc_q) >>> move;
            4'b1011: begin
                if (w_q) begin
                    dbl32  = {acc_q[31:0], acc_q[31:0]} >> move;
                    acc_nx = WIDTH'(dbl32[31:0]);
                end else begin
                    dbl    = {acc_q, acc_q} >> move;
                    acc_nx = dbl[WIDTH-1:0];
                end
            end
            4'b1100: begin
                if (w_q) begin
                    dbl32  = {acc_q[31:0], acc_q[31:0]} << move;
                    acc_nx = WIDTH'(dbl32[63:32]);
                end else begin
                    dbl    = {acc_q, acc_q} << move;
                    acc_nx = dbl[2*WIDTH-1:WIDTH];
                end
            end
            default: begin
                acc_nx = acc_q >> STEP_U;
                pop_nx = pop_q + pop_step(acc_q);
            end
        endcase
        last     = (op_q == 4'b1101) ? (cnt_q == last_cnt) : (32'(rem_q) <= STEP_U);
        iter_res = (op_q == 4'b1101) ? fin(w_q, WIDTH'(pop_nx)) : fin(w_q, acc_nx);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (Flush) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (InValid) state_nx = iter_in ? ITER : DONE;
                ITER:    if (last) state_nx = DONE;
                DONE:    if (OutReady) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        InReady  = (state == IDLE) & ~Flush & ~reset;
        OutValid = (state == DONE) & ~Flush & ~reset;
        Busy     = (state != IDLE) & ~reset;
        Result   = result_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q     <= '0;
            w_q      <= 1'b0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            pop_q    <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q  <= Op;
            w_q   <= w_in;
            acc_q <= acc_init;
            rem_q <= amt_in;
            cnt_q <= '0;
            pop_q <= '0;
            if (!iter_in) result_q <= alu_res;
        end else if (state == ITER && !Flush) begin
            acc_q <= acc_nx;
            rem_q <= rem_nx;
            pop_q <= pop_nx;
            cnt_q <= cnt_q + CW'(1);
            if (last) result_q <= iter_res;
        end
    end
endmodule

// File: tb/tb_iter_alu.sv
// Directed bench for iter_alu (WIDTH=64, STEP=4) with a result scoreboard queue.
module tb_iter_alu;
    logic        clk = 1'b0;
    logic        reset, Flush, InValid, InReady, W64, OutValid, OutReady, Busy;
    logic [63:0] A, B, Result;
    logic [3:0]  Op;
    int          total = 0;
    int          bad = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    iter_alu #(.WIDTH(64), .STEP(4)) dut (
        .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(InReady),
        .A(A), .B(B), .Op(Op), .W64(W64), .OutValid(OutValid), .OutReady(OutReady),
        .Result(Result), .Busy(Busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge where OutValid is first seen.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic w, input logic [63:0] res,
                          input int lat);
        int n;
        logic [63:0] e;
        Op = op; A = a; B = b; W64 = w; InValid = 1'b1;
        exp_q.push_back(res);
        #1 check({tag, "_inready"}, 64'(InReady), 64'd1);
        @(posedge clk);
        #1 InValid = 1'b0; A = ~a; B = ~b; Op = 4'hE; W64 = ~w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!OutValid && n < 64);
        check({tag, "_lat"}, 64'(n), 64'(lat));
        e = exp_q.pop_front();
        check({tag, "_res"}, Result, e);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        A = '0; B = '0; Op = '0; W64 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_inready", 64'(InReady), 64'd0);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_result", Result, 64'd0);
        reset = 1'b0;
        #1 check("rst_release_inready", 64'(InReady), 64'd1);

        @(negedge clk); run_op("add_wrap", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1);
        @(negedge clk); run_op("subw", 4'b0001, 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        @(negedge clk); run_op("addw_ovf", 4'b0000, 64'h7FFF_FFFF, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
        @(negedge clk); run_op("slt", 4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd1, 1);
        @(negedge clk); run_op("sltu", 4'b0011, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1);
        @(negedge clk); run_op("sltw", 4'b0010, 64'h0000_0000_8000_0000, 64'd0, 1'b1, 64'd1, 1);
        @(negedge clk); run_op("xor", 4'b0100, 64'hF0F0, 64'hFF00, 1'b0, 64'h0FF0, 1);
        @(negedge clk); run_op("or", 4'b0110, 64'hF0F0, 64'hFF00, 1'b0, 64'hFFF0, 1);
        @(negedge clk); run_op("illegal", 4'b0101, 64'hFFFF, 64'h1234, 1'b0, 64'd0, 1);
        @(negedge clk); run_op("sll10", 4'b1000, 64'd1, 64'd10, 1'b0, 64'h400, 4);
        @(negedge clk); run_op("sll0", 4'b1000, 64'd1, 64'd0, 1'b0, 64'd1, 2);
        @(negedge clk); run_op("sraw", 4'b1010, 64'h0000_0000_8000_0000, 64'd4, 1'b1, 64'hFFFF_FFFF_F800_0000, 2);
        @(negedge clk); run_op("ror", 4'b1011, 64'd1, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 2);
        @(negedge clk); run_op("rorw", 4'b1011, 64'd1, 64'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 2);
        @(negedge clk); run_op("rol", 4'b1100, 64'h8000_0000_0000_0001, 64'd4, 1'b0, 64'h18, 2);
        @(negedge clk); run_op("srl63", 4'b1001, 64'h8000_0000_0000_0000, 64'd63, 1'b0, 64'd1, 17);
        @(negedge clk); run_op("sllw_mask", 4'b1000, 64'd1, 64'd63, 1'b1, 64'hFFFF_FFFF_8000_0000, 9);
        @(negedge clk); run_op("cpop", 4'b1101, 64'hF0F0_F0F0_F0F0_F0F0, 64'd0, 1'b0, 64'd32, 17);
        @(negedge clk); run_op("cpopw", 4'b1101, 64'hF0F0_F0F0_F0F0_F0F0, 64'd0, 1'b1, 64'd16, 9);

        // Backpressure: result must hold while OutReady is low.
        @(negedge clk);
        OutReady = 1'b0;
        run_op("bp_and", 4'b0111, 64'hFF00, 64'h0FF0, 1'b0, 64'h0F00, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_outvalid", 64'(OutValid), 64'd1);
            check("bp_result", Result, 64'h0F00);
            check("bp_inready", 64'(InReady), 64'd0);
        end
        OutReady = 1'b1;
        @(negedge clk);
        check("bp_release_outvalid", 64'(OutValid), 64'd0);
        check("bp_release_busy", 64'(Busy), 64'd0);

        // Flush in the second ITER cycle of a long shift.
        Op = 4'b1000; A = 64'd1; B = 64'd63; W64 = 1'b0; InValid = 1'b1;
        @(posedge clk);
        #1 InValid = 1'b0;
        @(negedge clk);
        check("fl_iter1_busy", 64'(Busy), 64'd1);
        @(negedge clk);
        check("fl_iter2_outvalid", 64'(OutValid), 64'd0);
        Flush = 1'b1;
        @(posedge clk);
        #1 Flush = 1'b0;
        @(negedge clk);
        check("fl_busy", 64'(Busy), 64'd0);
        check("fl_outvalid", 64'(OutValid), 64'd0);
        run_op("fl_next", 4'b1000, 64'd3, 64'd5, 1'b0, 64'h60, 3);

        // Reset in the middle of a cpop.
        @(negedge clk);
        Op = 4'b1101; A = 64'hFFFF_FFFF_FFFF_FFFF; B = '0; W64 = 1'b0; InValid = 1'b1;
        @(posedge clk);
        #1 InValid = 1'b0;
        repeat (5) @(negedge clk);
        check("rs_mid_outvalid", 64'(OutValid), 64'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rs_busy", 64'(Busy), 64'd0);
        check("rs_outvalid", 64'(OutValid), 64'd0);
        check("rs_inready", 64'(InReady), 64'd0);
        check("rs_result", Result, 64'd0);
        reset = 1'b0;
        run_op("rs_next", 4'b1101, 64'hFF, 64'd0, 1'b0, 64'd8, 17);
        @(negedge clk);
        check("final_idle", 64'(Busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter STEP, default 4, bit positions processed per iteration cycle; power of 2, 1..WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Flush  input  1  synchronous abort of any operation in flight.
REQ-006 SHALL have ports InValid input 1 and InReady output 1  request handshake.
REQ-007 SHALL have ports A, B  input  WIDTH  operands.
REQ-008 SHALL have port Op  input  4  operation: 0000 add, 0001 sub, 0010 slt, 0011 sltu, 0100 xor, 0110 or, 0111 and, 1000 sll, 1001 srl, 1010 sra, 1011 ror, 1100 rol, 1101 cpop; all other codes illegal.
REQ-009 SHALL have port W64  input  1  32-bit W-type operation (honoured only when WIDTH=64).
REQ-010 SHALL have ports OutValid output 1 and OutReady input 1  result handshake.
REQ-011 SHALL have port Result  output  WIDTH  registered result.
REQ-012 SHALL have port Busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement states IDLE, ITER, DONE; InReady = (state==IDLE) & ~Flush & ~reset.
REQ-014 SHALL accept a request on a rising edge with InValid & InReady, capturing A, B, Op, W64 internally; inputs may change afterward.
REQ-015 SHALL treat add, sub, slt, sltu, xor, or, and, and illegal ops as single-cycle: IDLE->DONE on the accepting edge.
REQ-016 SHALL compute sub as A+~B+1; slt signed and sltu unsigned compare, result 0 or 1 zero-extended; illegal ops return 0.
REQ-017 SHALL treat sll, srl, sra, ror, rol, cpop as iterative: IDLE->ITER on the accepting edge.
REQ-018 SHALL use effective width EW=32 when WIDTH=64 & W64, else EW=WIDTH; shift amount = B[log2(EW)-1:0].
REQ-019 SHALL, for shifts/rotates, spend N = max(1, ceil(amt/STEP)) cycles in ITER, each moving min(STEP, remaining) positions; sra fills with bit EW-1 of A; rotates wrap within EW bits.
REQ-020 SHALL, for cpop, spend N = EW/STEP cycles in ITER, summing STEP bits of A[EW-1:0] per cycle into a log2(WIDTH)+1-bit zero-extended count.
REQ-021 SHALL transition ITER->DONE on the edge ending the Nth ITER cycle; OutValid therefore rises 1 cycle (single-cycle ops) or N+1 cycles (iterative ops) after the accepting edge.
REQ-022 SHALL, for WIDTH=64 & W64, compute on bits 31:0 and sign-extend bit 31 of the 32-bit result to 64 bits (cpop result is non-negative, so upper bits are 0).
REQ-023 SHALL assert OutValid only in DONE and hold Result stable until OutValid & OutReady, then DONE->IDLE.
REQ-024 SHALL hold DONE indefinitely while OutReady=0; no new request is accepted meanwhile.
REQ-025 SHALL, on Flush in any state, go to IDLE next edge, drop the operation, deassert OutValid; Flush in DONE coincident with OutReady drops the result (no handshake counted).
REQ-026 SHALL leave Result holding its last value after completion or Flush; only OutValid qualifies it.
REQ-027 SHALL give reset priority over Flush, and Flush priority over accept and completion.

Reset
REQ-028 SHALL, while reset=1, drive state IDLE, OutValid=0, InReady=0, Busy=0, Result=0, and clear iteration counter and captured operands.
REQ-029 SHALL abandon any in-flight operation on reset without producing OutValid, and accept InValid on the first edge after reset falls.

Verification
REQ-030 SHALL verify WIDTH=64, STEP=4: add A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> OutValid 1 cycle after accept, Result=0; sub A=0, B=1, W64=1 -> Result=0xFFFF_FFFF_FFFF_FFFF.
REQ-031 SHALL verify sll A=1, B=10 -> 3 ITER cycles, OutValid 4 cycles after accept, Result=0x400; sll B=0 -> 1 ITER cycle, Result=1.
REQ-032 SHALL verify sra W64=1, A=0x0000_0000_8000_0000, B=4 -> Result=0xFFFF_FFFF_F800_0000; ror W64=0, A=1, B=1 -> Result=0x8000_0000_0000_0000.
REQ-033 SHALL verify cpop A=0xF0F0_F0F0_F0F0_F0F0 -> 16 ITER cycles, Result=32; with W64=1 -> 8 ITER cycles, Result=16.
REQ-034 SHALL verify backpressure: OutReady=0 for 5 cycles in DONE -> Result/OutValid stable, InReady=0; then OutReady=1 -> IDLE next edge.
REQ-035 SHALL verify Flush asserted in the 2nd ITER cycle of sll B=63 and reset asserted mid-cpop -> IDLE next edge, no OutValid, next request completes correctly.
